// File: rtl/game_tick_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// game_tick_ctrl
// Game timebase. It raises a tick request once per period and holds it until
// the game logic acknowledges it. The game can be paused and single-stepped.
// With GAME_TICK_AUTOSPEED_EN defined, the period shrinks by one level every
// TICKS_PER_LEVEL accepted ticks.
//
// Optional feature macro: GAME_TICK_AUTOSPEED_EN (level ramping). When it is
// undefined, level is fixed at 0 and the period is always BASE_DIV.
//
// Ports
//   clock_50mhz : sole clock, rising edge
//   reset       : synchronous, active-high reset
//   start       : pulse, (re)start the timebase (priority over pause/step)
//   pause       : level, freeze the timebase while high
//   step        : pulse, issue one tick while paused
//   tick_ack    : game logic accepts the pending tick
//   tick        : tick request, held until acknowledged
//   running     : high while in RUN
//   level [3:0] : current speed level
//   overrun     : sticky, a period expired while a tick was still pending
// ---------------------------------------------------------------------------
module game_tick_ctrl #(
   parameter int unsigned BASE_DIV        = 150000,
   parameter int unsigned MIN_DIV         = 30000,
   parameter int unsigned SPEED_STEP      = 10000,
   parameter int unsigned TICKS_PER_LEVEL = 64
) (
   input  logic       clock_50mhz,
   input  logic       reset,
   input  logic       start,
   input  logic       pause,
   input  logic       step,
   input  logic       tick_ack,
   output logic       tick,
   output logic       running,
   output logic [3:0] level,
   output logic       overrun
);

   localparam int unsigned CNT_W = 32;
   localparam int unsigned LVL_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_PAUSED = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               tick_q, tick_d;
   logic               running_q, running_d;
   logic               overrun_q, overrun_d;

   logic [CNT_W-1:0]   div_c;     // period currently being counted
   logic               expiry_c;  // current period ends at this edge
   logic               accept_c;  // pending tick accepted this cycle

   // Counting happens only while RUN is kept; a pause sampled high freezes cnt
   // at the same edge, and start always wins.
   assign expiry_c = (state_q == ST_RUN) && !pause && !start &&
                     (cnt_q == div_c - CNT_W'(1));
   assign accept_c = tick_q && tick_ack;

   // State register
   always_ff @(posedge clock_50mhz) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      if (start) begin
         state_d = ST_RUN;
      end else begin
         case (state_q)
            ST_RUN:    if (pause)  state_d = ST_PAUSED;
            ST_PAUSED: if (!pause) state_d = ST_RUN;
            default:   state_d = ST_IDLE;
         endcase
      end
   end

   // Output / datapath next values
   always_comb begin
      cnt_d     = cnt_q;
      tick_d    = tick_q;
      overrun_d = overrun_q;
      running_d = (state_d == ST_RUN);
      if (start) begin
         cnt_d     = '0;
         tick_d    = 1'b0;
         overrun_d = 1'b0;
      end else begin
         if ((state_q == ST_RUN) && !pause) begin
            cnt_d = expiry_c ? '0 : cnt_q + CNT_W'(1);
         end
         // Ticks never queue: an expiry either raises a fresh tick or, if the
         // old one is still unacknowledged, flags an overrun.
         if (expiry_c) begin
            if (tick_q && !tick_ack) begin
               overrun_d = 1'b1;
            end
            tick_d = 1'b1;
         end else if (accept_c) begin
            tick_d = 1'b0;
         end else if ((state_q == ST_PAUSED) && step && !tick_q) begin
            tick_d = 1'b1;
         end
      end
   end

   // Datapath registers
   always_ff @(posedge clock_50mhz) begin
      if (reset) begin
         cnt_q     <= '0;
         tick_q    <= 1'b0;
         running_q <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         tick_q    <= tick_d;
         running_q <= running_d;
         overrun_q <= overrun_d;
      end
   end

   assign tick    = tick_q;
   assign running = running_q;
   assign overrun = overrun_q;

`ifdef GAME_TICK_AUTOSPEED_EN
   localparam int unsigned WIDE_W = 64;
   localparam logic [LVL_W-1:0] LVL_MAX = 4'd15;

   logic [CNT_W-1:0] div_q, div_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic [CNT_W-1:0] acc_q, acc_d;

   // max(BASE_DIV - lvl*SPEED_STEP, MIN_DIV) without wrapping below the floor
   function automatic logic [CNT_W-1:0] div_of(input logic [LVL_W-1:0] lvl);
      logic [WIDE_W-1:0] sub;
      sub = WIDE_W'(lvl) * WIDE_W'(SPEED_STEP);
      if (sub + WIDE_W'(MIN_DIV) >= WIDE_W'(BASE_DIV)) begin
         return CNT_W'(MIN_DIV);
      end
      return CNT_W'(BASE_DIV) - CNT_W'(sub);
   endfunction

   // Level ramp; the period is re-latched only at a wrap so the one in
   // progress keeps its length.
   always_comb begin
      div_d   = div_q;
      level_d = level_q;
      acc_d   = acc_q;
      if (start) begin
         div_d   = div_of(LVL_W'(0));
         level_d = '0;
         acc_d   = '0;
      end else begin
         if (expiry_c) begin
            div_d = div_of(level_q);
         end
         if (accept_c) begin
            if (acc_q + CNT_W'(1) >= CNT_W'(TICKS_PER_LEVEL)) begin
               acc_d = '0;
               if (level_q != LVL_MAX) begin
                  level_d = level_q + LVL_W'(1);
               end
            end else begin
               acc_d = acc_q + CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clock_50mhz) begin
      if (reset) begin
         div_q   <= div_of(LVL_W'(0));
         level_q <= '0;
         acc_q   <= '0;
      end else begin
         div_q   <= div_d;
         level_q <= level_d;
         acc_q   <= acc_d;
      end
   end

   assign div_c = div_q;
   assign level = level_q;
`else
   // Fixed speed: the ramp parameters have no effect in this build.
   logic unused_cfg_c;
   assign unused_cfg_c = ^{MIN_DIV, SPEED_STEP, TICKS_PER_LEVEL};

   assign div_c = CNT_W'(BASE_DIV);
   assign level = '0;
`endif

endmodule

// File: tb/tb_game_tick_ctrl.sv
`timescale 1ns/1ps
module tb_game_tick_ctrl;

   localparam int unsigned BASE   = 10;
   localparam int unsigned MIN    = 4;
   localparam int unsigned STEPSZ = 2;
   localparam int unsigned TPL    = 2;

   logic       clk = 1'b0;
   logic       rst, start, pause, step, ack;
   logic       tick, running, overrun;
   logic [3:0] level;

   int n_chk = 0;
   int n_err = 0;
   bit chk_model = 0;

   // reference model state
   int m_mode;      // 0 idle, 1 run, 2 paused
   int m_elapsed;   // cycles counted in the current period
   int m_period;
   int m_lvl;
   int m_acc;
   bit m_pend;
   bit m_ovr;

   always #5 clk = ~clk;

   game_tick_ctrl #(
      .BASE_DIV(BASE), .MIN_DIV(MIN), .SPEED_STEP(STEPSZ), .TICKS_PER_LEVEL(TPL)
   ) dut (
      .clock_50mhz(clk), .reset(rst), .start(start), .pause(pause), .step(step),
      .tick_ack(ack), .tick(tick), .running(running), .level(level), .overrun(overrun)
   );

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   function automatic int model_div(input int lvl);
`ifdef GAME_TICK_AUTOSPEED_EN
      int d;
      d = int'(BASE) - lvl * int'(STEPSZ);
      return (d < int'(MIN)) ? int'(MIN) : d;
`else
      return (lvl >= 0) ? int'(BASE) : int'(BASE);
`endif
   endfunction

   task automatic model_clear(input int mode);
      m_mode = mode; m_elapsed = 0; m_period = model_div(0);
      m_pend = 0; m_lvl = 0; m_acc = 0; m_ovr = 0;
   endtask

   // One clock of the game rules, applied to the inputs currently driven
   task automatic model_update();
      bit accepted, fire;
      if (rst) begin
         model_clear(0);
      end else if (start) begin
         model_clear(1);
      end else begin
         accepted = m_pend && ack;
         fire = 0;
         if (m_mode == 1 && !pause) begin
            m_elapsed++;
            if (m_elapsed >= m_period) begin
               fire = 1;
               m_elapsed = 0;
               m_period = model_div(m_lvl);
            end
         end
         if (fire) begin
            if (m_pend && !ack) m_ovr = 1;
            m_pend = 1;
         end else if (accepted) begin
            m_pend = 0;
         end else if (m_mode == 2 && step && !m_pend) begin
            m_pend = 1;
         end
         if (accepted) begin
            m_acc++;
            if (m_acc == int'(TPL)) begin
               m_acc = 0;
`ifdef GAME_TICK_AUTOSPEED_EN
               if (m_lvl < 15) m_lvl++;
`endif
            end
         end
         if (m_mode == 1 && pause) m_mode = 2;
         else if (m_mode == 2 && !pause) m_mode = 1;
      end
   endtask

   task automatic step_clk(input int n);
      for (int i = 0; i < n; i++) begin
         model_update();
         @(posedge clk);
         #1;
         if (chk_model)
            chk("model", int'({tick, running, level, overrun}),
                int'({m_pend, (m_mode == 1), 4'(m_lvl), m_ovr}));
      end
   endtask

   // Edges until tick is seen high; -1 if the bound expires
   task automatic wait_tick(input int bound, output int n);
      n = 0;
      do begin
         step_clk(1);
         n++;
      end while (!tick && n < bound);
      if (!tick) n = -1;
   endtask

   typedef struct {
      logic rst, st, pa, sp, ak;
      int   cyc;
      logic e_tick, e_run, e_ovr;
   } vec_t;

   vec_t vecs[18];
   int   exp_sp[10];
   int   n;

   initial begin
      // rst st pa sp ak cyc  tick run ovr
      vecs[0]  = '{1, 0, 0, 0, 0,  2, 0, 0, 0};
      vecs[1]  = '{0, 1, 0, 0, 0,  1, 0, 1, 0};
      vecs[2]  = '{0, 0, 0, 0, 0,  9, 0, 1, 0};
      vecs[3]  = '{0, 0, 0, 0, 0,  1, 1, 1, 0};
      vecs[4]  = '{0, 0, 0, 0, 0,  9, 1, 1, 0};
      vecs[5]  = '{0, 0, 0, 0, 0,  1, 1, 1, 1};
      vecs[6]  = '{0, 0, 0, 0, 1,  1, 0, 1, 1};
      vecs[7]  = '{0, 0, 0, 0, 0,  8, 0, 1, 1};
      vecs[8]  = '{0, 0, 0, 0, 0,  1, 1, 1, 1};
      vecs[9]  = '{0, 0, 1, 0, 0,  3, 1, 0, 1};
      vecs[10] = '{0, 0, 1, 1, 0,  1, 1, 0, 1};
      vecs[11] = '{0, 0, 1, 0, 1,  1, 0, 0, 1};
      vecs[12] = '{0, 0, 1, 1, 0,  1, 1, 0, 1};
      vecs[13] = '{0, 1, 1, 1, 0,  1, 0, 1, 0};
      vecs[14] = '{0, 0, 0, 0, 1, 10, 1, 1, 0};
      vecs[15] = '{1, 0, 0, 0, 0,  1, 0, 0, 0};
      vecs[16] = '{0, 0, 0, 0, 0, 12, 0, 0, 0};
      vecs[17] = '{0, 0, 1, 0, 0,  3, 0, 0, 0};
`ifdef GAME_TICK_AUTOSPEED_EN
      exp_sp = '{10, 10, 10, 8, 8, 6, 6, 4, 4, 4};
`else
      exp_sp = '{10, 10, 10, 10, 10, 10, 10, 10, 10, 10};
`endif

      rst = 1; start = 0; pause = 0; step = 0; ack = 0;
      model_clear(0);
      step_clk(2);
      rst = 0;
      chk("reset_outputs", int'({tick, running, level, overrun}), 0);

      // table: overrun, no queueing, pause/step, start priority, reset
      for (int i = 0; i < 18; i++) begin
         rst = vecs[i].rst; start = vecs[i].st; pause = vecs[i].pa;
         step = vecs[i].sp; ack = vecs[i].ak;
         step_clk(vecs[i].cyc);
         chk($sformatf("vec%0d", i), int'({tick, running, overrun}),
             int'({vecs[i].e_tick, vecs[i].e_run, vecs[i].e_ovr}));
      end
      rst = 0; start = 0; pause = 0; step = 0; ack = 0;

      // first-tick latency and steady spacing with ack tied high
      ack = 1; start = 1; step_clk(1); start = 0;
      chk("run_after_start", int'(running), 1);
      for (int i = 0; i < 3; i++) begin
         wait_tick(40, n);
         chk($sformatf("acked_spacing%0d", i), n, 10);
      end
      chk("acked_overrun", int'(overrun), 0);
      chk("acked_running", int'(running), 1);

      // ack coinciding with expiry: new tick, no overrun
      ack = 0; start = 1; step_clk(1); start = 0;
      wait_tick(40, n);
      chk("coincide_first", n, 10);
      step_clk(9);
      chk("coincide_pending", int'({tick, overrun}), 2);
      ack = 1; step_clk(1);
      chk("coincide_newtick", int'({tick, overrun}), 2);
      step_clk(1);
      chk("coincide_cleared", int'(tick), 0);
      ack = 0;

      // pause at cnt=6, step while paused, resume
      start = 1; step_clk(1); start = 0;
      step_clk(6);
      pause = 1; step_clk(20);
      chk("paused_quiet", int'({tick, running}), 0);
      step = 1; step_clk(1); step = 0;
      chk("step_tick", int'({tick, running}), 2);
      ack = 1; step_clk(1); ack = 0;
      chk("step_acked", int'(tick), 0);
      step_clk(3);
      chk("paused_still_quiet", int'(tick), 0);
      pause = 0; step_clk(1);
      chk("resume_running", int'({tick, running}), 1);
      wait_tick(20, n);
      chk("resume_latency", n, 4);
      pause = 1; step_clk(5);
      chk("pending_through_pause", int'({tick, running}), 2);
      pause = 0; step_clk(1);

      // reset mid-period with a tick pending
      start = 1; step_clk(1); start = 0;
      wait_tick(40, n);
      chk("pre_reset_tick", n, 10);
      step_clk(3);
      rst = 1; step_clk(1); rst = 0;
      chk("reset_mid_period", int'({tick, running, level, overrun}), 0);
      step_clk(15);
      chk("idle_after_reset", int'({tick, running}), 0);

      // speed ramp with every tick accepted
      ack = 1; start = 1; step_clk(1); start = 0;
      for (int i = 0; i < 10; i++) begin
         wait_tick(40, n);
         chk($sformatf("ramp_spacing%0d", i), n, exp_sp[i]);
      end
`ifdef GAME_TICK_AUTOSPEED_EN
      chk("ramp_level", int'(level), 4);
`else
      chk("ramp_level", int'(level), 0);
`endif
      ack = 0;

      // randomized stimulus against the reference model
      rst = 1; step_clk(1); rst = 0;
      chk_model = 1;
      for (int i = 0; i < 3000; i++) begin
         rst   = ($urandom_range(0, 299) == 0);
         start = ($urandom_range(0, 79) == 0) || (i == 0);
         if ($urandom_range(0, 15) == 0) pause = ~pause;
         step  = ($urandom_range(0, 5) == 0);
         ack   = ($urandom_range(0, 2) == 0);
         step_clk(1);
      end
      chk_model = 0;

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
